// File: rtl/tone_scheduler.sv
// Tone-select bus arbiter: tick-timed sequencer notes take priority over live keyboard echo.
// Optional macro TONE_GAP_EN inserts GAP_MS ticks of forced silence after every sequencer note.
module tone_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int GAP_MS  = 50,
  parameter int DUR_W   = 12
) (
  input  logic             CLOCK_50,
  input  logic [0:0]       KEY,
  input  logic             seq_valid,
  input  logic [7:0]       seq_tone,
  input  logic [DUR_W-1:0] seq_dur,
  output logic             seq_ready,
  input  logic [7:0]       key_tone,
  input  logic             key_en,
  output logic [7:0]       tone,
  output logic [1:0]       src,
  output logic             note_done
);

  localparam int T     = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (T > 2) ? $clog2(T) : 1;
  localparam int GAP_W = $clog2(GAP_MS + 1);
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_SEQ  = 2'b01;
  localparam logic [1:0] SRC_KEY  = 2'b10;

`ifdef TONE_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [0:0] {IDLE, PLAY} state_t;
`endif

  logic             rst_n;
  state_t           state_q, state_d;
  logic [7:0]       tone_q, tone_d;
  logic [1:0]       src_q, src_d;
  logic             done_q, done_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign rst_n = KEY[0];
  assign wrap  = (pre_q == PRE_W'(T - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tone_q  <= '0;
      src_q   <= SRC_NONE;
      done_q  <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      src_q   <= src_d;
      done_q  <= done_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    src_d   = src_q;
    done_d  = 1'b0;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A transfer outranks the keyboard on the same edge; a zero duration still plays one tick.
        if (seq_valid) begin
          state_d = PLAY;
          tone_d  = seq_tone;
          src_d   = SRC_SEQ;
          cnt_d   = (seq_dur == '0) ? CNT_W'(1) : CNT_W'(seq_dur);
          pre_d   = '0;
        end else if (key_en && (key_tone != 8'h00)) begin
          tone_d = key_tone;
          src_d  = SRC_KEY;
        end else begin
          tone_d = 8'h00;
          src_d  = SRC_NONE;
        end
      end
      PLAY: begin
        pre_d = wrap ? '0 : pre_q + PRE_W'(1);
        if (wrap) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef TONE_GAP_EN
            state_d = GAP;
            tone_d  = 8'h00;
            src_d   = SRC_SEQ;
            cnt_d   = CNT_W'(GAP_MS);
`else
            state_d = IDLE;
            tone_d  = 8'h00;
            src_d   = SRC_NONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef TONE_GAP_EN
      GAP: begin
        pre_d = wrap ? '0 : pre_q + PRE_W'(1);
        if (wrap) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            tone_d  = 8'h00;
            src_d   = SRC_NONE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign seq_ready = (state_q == IDLE);
  assign tone      = tone_q;
  assign src       = src_q;
  assign note_done = done_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench for tone_scheduler: the driver queues expected output changes with their edge index,
// a monitor pops one entry whenever {tone, src, note_done, seq_ready} changes.
module tb_tone_scheduler;

  localparam int T = 10;
`ifdef TONE_GAP_EN
  localparam int G = 20;
  localparam bit GAP_ON = 1'b1;
`else
  localparam int G = 0;
  localparam bit GAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic [0:0]  KEY;
  logic        seq_valid;
  logic [7:0]  seq_tone;
  logic [11:0] seq_dur;
  logic        seq_ready;
  logic [7:0]  key_tone;
  logic        key_en;
  logic [7:0]  tone;
  logic [1:0]  src;
  logic        note_done;

  tone_scheduler #(.CLK_HZ(1000), .TICK_HZ(100), .GAP_MS(2), .DUR_W(12)) dut (
    .CLOCK_50(clk), .KEY(KEY), .seq_valid(seq_valid), .seq_tone(seq_tone),
    .seq_dur(seq_dur), .seq_ready(seq_ready), .key_tone(key_tone), .key_en(key_en),
    .tone(tone), .src(src), .note_done(note_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] tone;
    logic [1:0] src;
    logic       done;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every observed change of the output vector must match the queue head, edge included.
  logic [11:0] obs, prev;
  bit          seen = 1'b0;
  exp_t        e;
  always @(negedge clk) begin
    obs = {tone, src, note_done, seq_ready};
    if (!seen || obs !== prev) begin
      seen = 1'b1;
      prev = obs;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got tone=%h src=%b done=%b rdy=%b, required no change",
                 edge_cnt, tone, src, note_done, seq_ready);
      end else begin
        e = exp_q.pop_front();
        if ((e.edge_n >= 0 && e.edge_n != edge_cnt) || tone !== e.tone || src !== e.src ||
            note_done !== e.done || seq_ready !== e.rdy) begin
          errors++;
          $display("FAIL %s got edge=%0d tone=%h src=%b done=%b rdy=%b, required edge=%0d tone=%h src=%b done=%b rdy=%b",
                   e.name, edge_cnt, tone, src, note_done, seq_ready, e.edge_n, e.tone, e.src, e.done, e.rdy);
        end
      end
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_events got %0d pending (head %s), required 0", exp_q.size(), exp_q[0].name);
      end
    end
  end

  task automatic push(input int en, input logic [7:0] t, input logic [1:0] s,
                      input logic d, input logic r, input string nm);
    exp_t x;
    x.edge_n = en; x.tone = t; x.src = s; x.done = d; x.rdy = r; x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int en);
    while (edge_cnt < en) @(negedge clk);
  endtask

  // Issues one note from a negedge; returns the accept edge and the edge where PLAY expires.
  task automatic note(input logic [7:0] t, input logic [11:0] d, input int deff,
                      input string nm, output int n, output int ex);
    seq_valid = 1'b1; seq_tone = t; seq_dur = d;
    n  = edge_cnt + 1;
    ex = n + deff * T;
    push(n, t, 2'b01, 1'b0, 1'b0, {nm, "_accept"});
    if (GAP_ON) push(ex, 8'h00, 2'b01, 1'b0, 1'b0, {nm, "_gap"});
    push(ex + G, 8'h00, 2'b00, 1'b1, 1'b1, {nm, "_done"});
    tick(1);
    seq_valid = 1'b0;
  endtask

  int n, ex, n2, ex2;

  initial begin
    KEY = 1'b0; key_en = 1'b1; key_tone = 8'h04;
    seq_valid = 1'b0; seq_tone = 8'h00; seq_dur = 12'd0;
    push(-1, 8'h00, 2'b00, 1'b0, 1'b1, "reset_hold");
    tick(3);

    KEY = 1'b1;
    push(edge_cnt + 1, 8'h04, 2'b10, 1'b0, 1'b1, "key_echo_on");
    tick(3);
    key_tone = 8'h00;
    push(edge_cnt + 1, 8'h00, 2'b00, 1'b0, 1'b1, "key_zero");
    tick(3);
    key_tone = 8'h04;
    push(edge_cnt + 1, 8'h04, 2'b10, 1'b0, 1'b1, "key_back");
    tick(3);
    key_en = 1'b0;
    push(edge_cnt + 1, 8'h00, 2'b00, 1'b0, 1'b1, "key_disable");
    tick(3);

    note(8'h15, 12'd3, 3, "single", n, ex);
    push(ex + G + 1, 8'h00, 2'b00, 1'b0, 1'b1, "single_idle");
    wait_edge(ex + G + 3);

    key_en = 1'b1; key_tone = 8'h04;
    note(8'h20, 12'd1, 1, "collide", n, ex);
    push(ex + G + 1, 8'h04, 2'b10, 1'b0, 1'b1, "collide_key_back");
    key_tone = 8'h07;
    tick(3);
    key_en = 1'b0;
    tick(2);
    key_en = 1'b1; key_tone = 8'h04;
    wait_edge(ex + G + 3);
    key_en = 1'b0;
    push(edge_cnt + 1, 8'h00, 2'b00, 1'b0, 1'b1, "collide_key_off");
    tick(3);

    note(8'h33, 12'd0, 1, "zero_dur", n, ex);
    push(ex + G + 1, 8'h00, 2'b00, 1'b0, 1'b1, "zero_dur_idle");
    wait_edge(ex + G + 3);

    // Back-to-back: seq_valid stays high, the second note must be taken on the edge after note_done.
    seq_valid = 1'b1; seq_tone = 8'h41; seq_dur = 12'd1;
    n = edge_cnt + 1;
    ex = n + T;
    push(n, 8'h41, 2'b01, 1'b0, 1'b0, "b2b_accept1");
    if (GAP_ON) push(ex, 8'h00, 2'b01, 1'b0, 1'b0, "b2b_gap1");
    push(ex + G, 8'h00, 2'b00, 1'b1, 1'b1, "b2b_done1");
    n2 = ex + G + 1;
    ex2 = n2 + 2 * T;
    push(n2, 8'h42, 2'b01, 1'b0, 1'b0, "b2b_accept2");
    if (GAP_ON) push(ex2, 8'h00, 2'b01, 1'b0, 1'b0, "b2b_gap2");
    push(ex2 + G, 8'h00, 2'b00, 1'b1, 1'b1, "b2b_done2");
    push(ex2 + G + 1, 8'h00, 2'b00, 1'b0, 1'b1, "b2b_idle");
    tick(1);
    seq_tone = 8'h42; seq_dur = 12'd2;
    wait_edge(n2);
    seq_valid = 1'b0;
    wait_edge(ex2 + G + 3);

    // Reset mid-PLAY aborts without note_done; the first edge after release can accept a note.
    seq_valid = 1'b1; seq_tone = 8'h55; seq_dur = 12'd3;
    n = edge_cnt + 1;
    push(n, 8'h55, 2'b01, 1'b0, 1'b0, "abort_accept");
    tick(1);
    seq_valid = 1'b0;
    wait_edge(n + 12);
    @(posedge clk);
    #2;
    push(edge_cnt, 8'h00, 2'b00, 1'b0, 1'b1, "reset_abort");
    KEY = 1'b0;
    tick(3);
    KEY = 1'b1;
    note(8'h66, 12'd1, 1, "post_reset", n, ex);
    push(ex + G + 1, 8'h00, 2'b00, 1'b0, 1'b1, "post_reset_idle");
    wait_edge(ex + G + 3);
    tick(40);

    end_req = 1'b1;
    repeat (5) if (!end_done) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Owns the 8-bit tone-select bus that drives the audio codec path, and shares it between two requesters: the game's pattern-playback sequencer and the live keyboard echo from the PS/2 decoder. Sequencer notes are timed in millisecond ticks and take priority. Keyboard tones pass through only while the game permits player input and no note is playing. It sits between the PS/2 key decoder, the game FSM, and the audio top's tone-select input.

## Interface
Parameters:
- CLK_HZ, 50000000, input clock frequency
- TICK_HZ, 1000, duration tick rate; one tick is CLK_HZ/TICK_HZ cycles, which must be an integer ≥ 2
- GAP_MS, 50, silent gap after each sequencer note, in ticks (used only with TONE_GAP_EN)
- DUR_W, 12, width of the note-duration field

Ports:
- CLOCK_50  in  1  system clock; all state is on its rising edge
- KEY  in  1  KEY[0] is the reset: asynchronous, active-low
- seq_valid  in  1  sequencer note request
- seq_tone  in  8  tone code of the requested note; 0 means a silent rest
- seq_dur  in  DUR_W  note length in ticks
- seq_ready  out  1  scheduler can accept a note
- key_tone  in  8  live key tone code from the keyboard decoder; 0 means no key
- key_en  in  1  game permits keyboard echo
- tone  out  8  registered tone select to the audio block
- src  out  2  registered owner of tone: 00 none, 01 sequencer, 10 keyboard
- note_done  out  1  one-cycle pulse when a sequencer note (including its gap) completes

## Operation
- States: IDLE, PLAY, GAP. Reset puts the block in IDLE.
- seq_ready = (state == IDLE).
- A transfer happens on an edge where seq_valid && seq_ready are both high. On that edge:
  - latch seq_tone into tone and set src=01;
  - load the duration counter with seq_dur; seq_dur=0 is loaded as 1;
  - clear the tick prescaler;
  - go to PLAY.
- PLAY:
  - The prescaler counts 0..CLK_HZ/TICK_HZ-1. At wrap it decrements the duration counter.
  - When the counter reaches 0 at a wrap:
    - with TONE_GAP_EN: go to GAP, set tone=0, src=01, load the counter with GAP_MS, clear the prescaler;
    - without TONE_GAP_EN: go to IDLE.
- GAP: counts the same way. At expiry it goes to IDLE.
- On entry to IDLE from PLAY or GAP:
  - note_done=1 for exactly that one cycle;
  - tone=0 and src=00 on that same edge.
- IDLE, with no transfer:
  - if key_en && key_tone != 0: tone is loaded with key_tone and src=10 on each edge;
  - otherwise tone=0 and src=00.
- Simultaneous events:
  - A transfer and an active key on the same edge: the sequencer wins, and the key is not shown that cycle.
  - Changes to key_tone or key_en during PLAY or GAP are ignored. A key still held when the block returns to IDLE reappears one cycle after the note_done edge.
- seq_tone, seq_dur and seq_valid are don't-care outside a transfer edge.
- GAP_MS=0 with TONE_GAP_EN is illegal.

## Timing
- Reset (KEY[0]=0) forces, asynchronously: state=IDLE, tone=0, src=00, note_done=0, prescaler=0, counter=0, seq_ready=1.
- Behaviour after KEY[0] deasserts:
  - seq_ready is 1 in the same cycle;
  - the first transfer is possible on the first edge.
- Reset asserted mid-PLAY or mid-GAP aborts the note immediately. No note_done is generated.
- Transfer at edge N: tone=seq_tone from edge N through edge N + D·T, where D is the effective duration and T = CLK_HZ/TICK_HZ. That is exactly D·T cycles.
- Returning to IDLE:
  - with TONE_GAP_EN: GAP holds tone=0 for GAP_MS·T cycles, then the block returns to IDLE;
  - without TONE_GAP_EN: IDLE is entered at edge N + D·T.
- seq_ready is low from edge N until the IDLE entry edge. It is high again on that edge, so a back-to-back transfer is possible on the next edge.
- Keyboard path latency: one cycle from key_tone/key_en to tone/src.

## Configuration
- TONE_GAP_EN defined:
  - every sequencer note is followed by GAP_MS ticks of forced silence, so repeated identical notes are audibly separated;
  - the GAP state exists, and note_done fires at the end of the gap.
- Undefined:
  - the GAP state, its counter load and the GAP_MS use are compiled out;
  - note_done fires when PLAY expires;
  - back-to-back notes are contiguous.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (T=10) and GAP_MS=2.
- Reset: hold KEY[0]=0 with key_en=1, key_tone=8'h04 -> tone=0, src=00, seq_ready=1, note_done=0. Assert KEY[0]=0 mid-PLAY -> tone=0 immediately, and no note_done.
- Single note, TONE_GAP_EN defined: seq_tone=8'h15, seq_dur=3 -> tone=8'h15 with src=01 for 30 cycles after the accept edge, then tone=0 for 20 cycles, then note_done for 1 cycle and seq_ready=1.
- Same stimulus with TONE_GAP_EN undefined -> tone=8'h15 for 30 cycles, then note_done and tone=0 on the same edge.
- Key echo: key_en=1, key_tone=8'h04 -> tone=8'h04, src=10 one cycle later. Setting key_tone=0 or key_en=0 -> tone=0, src=00 one cycle later.
- Collision: key_tone=8'h04 held and a transfer of 8'h20, dur 1, on the same edge -> tone=8'h20 for 10 cycles, with key changes ignored during the note. After note_done, tone=8'h04 one cycle later.
- Zero duration and back-to-back notes: seq_dur=0 -> tone held for 10 cycles. Two queued notes with seq_valid held -> the second is accepted on the edge after note_done, with no lost or duplicated note.
